// File: rtl/lsu.sv
// -----------------------------------------------------------------------------
// lsu -- load/store unit sitting directly after the execute stage.
//
// Accepts one execute result at a time. Memory ops go out through a
// single-outstanding request/response port. Load data is aligned and
// sign- or zero-extended, and store data is replicated with byte strobes.
// Non-memory ops pass through with one cycle of latency. Every result,
// including faults, is delivered to writeback over a valid/ready handshake.
//
// Ports
//   clk_i, rst_n_i         clock, synchronous active-low reset
//   in_valid_i/in_ready_o  execute-side handshake
//   in_is_load_i/_store_i  op class (both 0 = non-memory)
//   in_funct3_i            RV32 size/sign field
//   in_res_i               execute result / effective address
//   in_wdata_i             store data (rs2)
//   in_rd_i, in_wen_i      destination register and its write enable
//   mem_req_*              request channel (valid/ready, we, addr, wdata, wstrb)
//   mem_rsp_*              response channel (valid, rdata, err), always accepted
//   out_valid_o/out_ready_i writeback handshake
//   out_res_o, out_rd_o, out_wen_o, out_err_o, out_badaddr_o  writeback payload
// -----------------------------------------------------------------------------
module lsu #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,

    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              in_is_load_i,
    input  logic              in_is_store_i,
    input  logic [2:0]        in_funct3_i,
    input  logic [XLEN-1:0]   in_res_i,
    input  logic [XLEN-1:0]   in_wdata_i,
    input  logic [4:0]        in_rd_i,
    input  logic              in_wen_i,

    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic              mem_req_we_o,
    output logic [ADDR_W-1:0] mem_req_addr_o,
    output logic [XLEN-1:0]   mem_req_wdata_o,
    output logic [3:0]        mem_req_wstrb_o,

    input  logic              mem_rsp_valid_i,
    input  logic [XLEN-1:0]   mem_rsp_rdata_i,
    input  logic              mem_rsp_err_i,

    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [XLEN-1:0]   out_res_o,
    output logic [4:0]        out_rd_o,
    output logic              out_wen_o,
    output logic              out_err_o,
    output logic [ADDR_W-1:0] out_badaddr_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_next;

    // Latched transaction fields
    logic [2:0]        funct3_q;
    logic              is_load_q;
    logic [ADDR_W-1:0] addr_q;
    logic              req_we_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic [XLEN-1:0]   req_wdata_q;
    logic [3:0]        req_wstrb_q;
    logic [XLEN-1:0]   res_q;
    logic [4:0]        rd_q;
    logic              wen_q;
    logic              err_q;
    logic [ADDR_W-1:0] badaddr_q;

    // Input-side decode
    logic              accept;
    logic              is_mem;
    logic [1:0]        off;
    logic              f3_legal;
    logic              misaligned;
    logic              fault;
    logic [XLEN-1:0]   st_wdata;
    logic [3:0]        st_wstrb;

    // Response-side load extraction
    logic [XLEN-1:0]   rsp_shift;
    logic [XLEN-1:0]   load_data;

    // Ready depends only on state. It is gated by reset so that it reads 0
    // while reset is held, even though the state is already IDLE.
    assign in_ready_o = (state == IDLE) && rst_n_i;
    assign accept     = in_valid_i && in_ready_o;
    assign is_mem     = in_is_load_i || in_is_store_i;
    assign off        = in_res_i[1:0];

    // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        f3_legal   = 1'b0;
        misaligned = 1'b0;
        if (in_is_load_i && !in_is_store_i) begin
            f3_legal = in_funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        end else if (in_is_store_i && !in_is_load_i) begin
            f3_legal = in_funct3_i inside {3'b000, 3'b001, 3'b010};
        end
        // funct3[1:0] encodes the size: 01 is halfword, 10 is word.
        if (in_funct3_i[1:0] == 2'b01) misaligned = off[0];
        if (in_funct3_i[1:0] == 2'b10) misaligned = (off != 2'b00);
    end

    // Setting both op-class bits is illegal. It leaves f3_legal low, so the
    // op faults.
    assign fault = is_mem && (!f3_legal || misaligned);

    // Store lane formatting. Loads and non-stores leave strobes and data at 0.
    always_comb begin
        st_wstrb = 4'b0000;
        st_wdata = '0;
        if (in_is_store_i) begin
            unique case (in_funct3_i[1:0])
                2'b00: begin
                    st_wstrb = 4'b0001 << off;
                    st_wdata = {4{in_wdata_i[7:0]}};
                end
                2'b01: begin
                    st_wstrb = 4'b0011 << off;
                    st_wdata = {2{in_wdata_i[15:0]}};
                end
                2'b10: begin
                    st_wstrb = 4'b1111;
                    st_wdata = in_wdata_i;
                end
                default: begin
                    st_wstrb = 4'b0000;
                    st_wdata = '0;
                end
            endcase
        end
    end

    // Shift the addressed byte lane down to bit 0, then extend it.
    assign rsp_shift = mem_rsp_rdata_i >> {addr_q[1:0], 3'b000};

    always_comb begin
        load_data = '0;
        unique case (funct3_q)
            3'b000:  load_data = {{(XLEN-8){rsp_shift[7]}},   rsp_shift[7:0]};
            3'b001:  load_data = {{(XLEN-16){rsp_shift[15]}}, rsp_shift[15:0]};
            3'b010:  load_data = mem_rsp_rdata_i;
            3'b100:  load_data = {{(XLEN-8){1'b0}},           rsp_shift[7:0]};
            3'b101:  load_data = {{(XLEN-16){1'b0}},          rsp_shift[15:0]};
            default: load_data = '0;
        endcase
    end

    // State register
    // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) state <= IDLE;
        else          state <= state_next;
    end

    // Next-state logic. Responses are examined only in WAIT, so a response
    // that arrives in REQ, including the cycle the request is accepted, is
    // ignored.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (accept) state_next = (!is_mem || fault) ? DONE : REQ;
            REQ:  if (mem_req_ready_i) state_next = WAIT;
            WAIT: if (mem_rsp_valid_i) state_next = DONE;
            DONE: if (out_ready_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath registers. Fields only change on accept or on the response.
    // That keeps request and writeback payloads stable across any stall.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            funct3_q    <= '0;
            is_load_q   <= 1'b0;
            addr_q      <= '0;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_wstrb_q <= '0;
            res_q       <= '0;
            rd_q        <= '0;
            wen_q       <= 1'b0;
            err_q       <= 1'b0;
            badaddr_q   <= '0;
        end else begin
            if (accept) begin
                funct3_q    <= in_funct3_i;
                is_load_q   <= in_is_load_i;
                addr_q      <= in_res_i[ADDR_W-1:0];
                req_we_q    <= in_is_store_i;
                req_addr_q  <= {in_res_i[ADDR_W-1:2], 2'b00};
                req_wdata_q <= st_wdata;
                req_wstrb_q <= st_wstrb;
                rd_q        <= in_rd_i;
                if (!is_mem) begin
                    res_q     <= in_res_i;
                    wen_q     <= in_wen_i;
                    err_q     <= 1'b0;
                    badaddr_q <= '0;
                end else if (fault) begin
                    res_q     <= '0;
                    wen_q     <= 1'b0;
                    err_q     <= 1'b1;
                    badaddr_q <= in_res_i[ADDR_W-1:0];
                end else begin
                    res_q     <= '0;
                    wen_q     <= 1'b0;
                    err_q     <= 1'b0;
                    badaddr_q <= '0;
                end
            end
            if (state == WAIT && mem_rsp_valid_i) begin
                if (mem_rsp_err_i) begin
                    res_q     <= '0;
                    wen_q     <= 1'b0;
                    err_q     <= 1'b1;
                    badaddr_q <= addr_q;
                end else begin
                    res_q     <= is_load_q ? load_data : '0;
                    wen_q     <= is_load_q;
                    err_q     <= 1'b0;
                    badaddr_q <= '0;
                end
            end
        end
    end

    assign mem_req_valid_o = (state == REQ);
    assign mem_req_we_o    = req_we_q;
    assign mem_req_addr_o  = req_addr_q;
    assign mem_req_wdata_o = req_wdata_q;
    assign mem_req_wstrb_o = req_wstrb_q;

    assign out_valid_o     = (state == DONE);
    assign out_res_o       = res_q;
    assign out_rd_o        = rd_q;
    assign out_wen_o       = wen_q;
    assign out_err_o       = err_q;
    assign out_badaddr_o   = badaddr_q;

endmodule

// File: tb/tb_lsu.sv
// -----------------------------------------------------------------------------
// tb_lsu -- self-checking bench for lsu.
// A table of directed ops is driven through the unit with an immediately ready
// memory. Hand-written sequences cover the request and writeback stalls, an
// ignored early response, and reset in the middle of a transaction.
// -----------------------------------------------------------------------------
module tb_lsu;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_is_load;
    logic        in_is_store;
    logic [2:0]  in_funct3;
    logic [31:0] in_res;
    logic [31:0] in_wdata;
    logic [4:0]  in_rd;
    logic        in_wen;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_we;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_rdata;
    logic        mem_rsp_err;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_res;
    logic [4:0]  out_rd;
    logic        out_wen;
    logic        out_err;
    logic [31:0] out_badaddr;

    int checks   = 0;
    int failures = 0;

    lsu #(.XLEN(32), .ADDR_W(32)) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .in_valid_i      (in_valid),
        .in_ready_o      (in_ready),
        .in_is_load_i    (in_is_load),
        .in_is_store_i   (in_is_store),
        .in_funct3_i     (in_funct3),
        .in_res_i        (in_res),
        .in_wdata_i      (in_wdata),
        .in_rd_i         (in_rd),
        .in_wen_i        (in_wen),
        .mem_req_valid_o (mem_req_valid),
        .mem_req_ready_i (mem_req_ready),
        .mem_req_we_o    (mem_req_we),
        .mem_req_addr_o  (mem_req_addr),
        .mem_req_wdata_o (mem_req_wdata),
        .mem_req_wstrb_o (mem_req_wstrb),
        .mem_rsp_valid_i (mem_rsp_valid),
        .mem_rsp_rdata_i (mem_rsp_rdata),
        .mem_rsp_err_i   (mem_rsp_err),
        .out_valid_o     (out_valid),
        .out_ready_i     (out_ready),
        .out_res_o       (out_res),
        .out_rd_o        (out_rd),
        .out_wen_o       (out_wen),
        .out_err_o       (out_err),
        .out_badaddr_o   (out_badaddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] res;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic        wen;
        logic [31:0] rdata;
        logic        mem;       // a memory request is expected
        logic [31:0] e_addr;
        logic        e_we;
        logic [3:0]  e_wstrb;
        logic [31:0] e_wdata;
        logic [31:0] e_res;
        logic        e_wen;
        logic        e_err;
        logic [31:0] e_bad;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic ld, input logic st, input logic [2:0] f3,
        input logic [31:0] res, input logic [31:0] wdata, input logic [4:0] rd,
        input logic wen, input logic [31:0] rdata, input logic mem,
        input logic [31:0] e_addr, input logic e_we, input logic [3:0] e_wstrb,
        input logic [31:0] e_wdata, input logic [31:0] e_res, input logic e_wen,
        input logic e_err, input logic [31:0] e_bad);
        vec_t v;
        v.ld = ld; v.st = st; v.f3 = f3; v.res = res; v.wdata = wdata;
        v.rd = rd; v.wen = wen; v.rdata = rdata; v.mem = mem;
        v.e_addr = e_addr; v.e_we = e_we; v.e_wstrb = e_wstrb; v.e_wdata = e_wdata;
        v.e_res = e_res; v.e_wen = e_wen; v.e_err = e_err; v.e_bad = e_bad;
        return v;
    endfunction

    task automatic drive_idle_inputs();
        in_valid    = 1'b0;
        in_is_load  = 1'b0;
        in_is_store = 1'b0;
        in_funct3   = 3'b000;
        in_res      = '0;
        in_wdata    = '0;
        in_rd       = '0;
        in_wen      = 1'b0;
    endtask

    task automatic present(input vec_t v);
        in_valid    = 1'b1;
        in_is_load  = v.ld;
        in_is_store = v.st;
        in_funct3   = v.f3;
        in_res      = v.res;
        in_wdata    = v.wdata;
        in_rd       = v.rd;
        in_wen      = v.wen;
    endtask

    // Drive one op through with a ready memory that answers one cycle after
    // the request is taken, then complete the writeback handshake.
    task automatic run_vec(input vec_t v, input string tag);
        present(v);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        drive_idle_inputs();
        if (v.mem) begin
            check({tag, "_req_valid"}, 32'(mem_req_valid), 32'd1);
            check({tag, "_req_addr"},  mem_req_addr,        v.e_addr);
            check({tag, "_req_we"},    32'(mem_req_we),     32'(v.e_we));
            check({tag, "_req_wstrb"}, 32'(mem_req_wstrb),  32'(v.e_wstrb));
            check({tag, "_req_wdata"}, mem_req_wdata,       v.e_wdata);
            check({tag, "_early_out"}, 32'(out_valid),      32'd0);
            @(posedge clk); #1;
            check({tag, "_req_drop"},  32'(mem_req_valid), 32'd0);
            mem_rsp_valid = 1'b1;
            mem_rsp_rdata = v.rdata;
            @(posedge clk); #1;
            mem_rsp_valid = 1'b0;
            mem_rsp_rdata = '0;
        end else begin
            check({tag, "_no_req"}, 32'(mem_req_valid), 32'd0);
        end
        check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_out_res"},   out_res,        v.e_res);
        check({tag, "_out_rd"},    32'(out_rd),    32'(v.rd));
        check({tag, "_out_wen"},   32'(out_wen),   32'(v.e_wen));
        check({tag, "_out_err"},   32'(out_err),   32'(v.e_err));
        check({tag, "_out_bad"},   out_badaddr,    v.e_bad);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_back_idle"}, {31'd0, in_ready & ~out_valid}, 32'd1);
    endtask

    task automatic check_all_zero(input string tag, input logic exp_ready);
        check({tag, "_flags"}, {26'd0, mem_req_valid, out_valid, mem_req_we,
                                out_wen, out_err, 1'b0}, 32'd0);
        check({tag, "_in_ready"},  32'(in_ready),      32'(exp_ready));
        check({tag, "_req_addr"},  mem_req_addr,       32'd0);
        check({tag, "_req_wdata"}, mem_req_wdata,      32'd0);
        check({tag, "_req_wstrb"}, 32'(mem_req_wstrb), 32'd0);
        check({tag, "_out_res"},   out_res,            32'd0);
        check({tag, "_out_rd"},    32'(out_rd),        32'd0);
        check({tag, "_out_bad"},   out_badaddr,        32'd0);
    endtask

    initial begin
        //              ld    st    f3      res           wdata         rd     wen   rdata         mem   e_addr        we    wstrb    e_wdata       e_res         wen   err   bad
        vecs[0]  = mk(1'b0, 1'b0, 3'b000, 32'h00001234, 32'h0,        5'd5,  1'b1, 32'h0,        1'b0, 32'h0,        1'b0, 4'b0000, 32'h0,        32'h00001234, 1'b1, 1'b0, 32'h0);
        vecs[1]  = mk(1'b1, 1'b0, 3'b000, 32'h80000003, 32'h0,        5'd7,  1'b0, 32'h80FFFF7F, 1'b1, 32'h80000000, 1'b0, 4'b0000, 32'h0,        32'hFFFFFF80, 1'b1, 1'b0, 32'h0);
        vecs[2]  = mk(1'b1, 1'b0, 3'b100, 32'h80000003, 32'h0,        5'd8,  1'b0, 32'h80FFFF7F, 1'b1, 32'h80000000, 1'b0, 4'b0000, 32'h0,        32'h00000080, 1'b1, 1'b0, 32'h0);
        vecs[3]  = mk(1'b0, 1'b1, 3'b001, 32'h80000002, 32'hDEADBEEF, 5'd9,  1'b0, 32'h0,        1'b1, 32'h80000000, 1'b1, 4'b1100, 32'hBEEFBEEF, 32'h0,        1'b0, 1'b0, 32'h0);
        vecs[4]  = mk(1'b1, 1'b0, 3'b010, 32'h80000006, 32'h0,        5'd10, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 4'b0000, 32'h0,        32'h0,        1'b0, 1'b1, 32'h80000006);
        vecs[5]  = mk(1'b1, 1'b0, 3'b011, 32'h00000100, 32'h0,        5'd11, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 4'b0000, 32'h0,        32'h0,        1'b0, 1'b1, 32'h00000100);
        vecs[6]  = mk(1'b1, 1'b0, 3'b001, 32'h00002002, 32'h0,        5'd12, 1'b0, 32'h80011234, 1'b1, 32'h00002000, 1'b0, 4'b0000, 32'h0,        32'hFFFF8001, 1'b1, 1'b0, 32'h0);
        vecs[7]  = mk(1'b1, 1'b0, 3'b101, 32'h00002002, 32'h0,        5'd13, 1'b0, 32'h80011234, 1'b1, 32'h00002000, 1'b0, 4'b0000, 32'h0,        32'h00008001, 1'b1, 1'b0, 32'h0);
        vecs[8]  = mk(1'b1, 1'b0, 3'b010, 32'h00003000, 32'h0,        5'd14, 1'b0, 32'hCAFEF00D, 1'b1, 32'h00003000, 1'b0, 4'b0000, 32'h0,        32'hCAFEF00D, 1'b1, 1'b0, 32'h0);
        vecs[9]  = mk(1'b0, 1'b1, 3'b000, 32'h00004001, 32'h123456A5, 5'd15, 1'b0, 32'h0,        1'b1, 32'h00004000, 1'b1, 4'b0010, 32'hA5A5A5A5, 32'h0,        1'b0, 1'b0, 32'h0);
        vecs[10] = mk(1'b0, 1'b1, 3'b010, 32'h00005000, 32'h0BADF00D, 5'd16, 1'b0, 32'h0,        1'b1, 32'h00005000, 1'b1, 4'b1111, 32'h0BADF00D, 32'h0,        1'b0, 1'b0, 32'h0);
        vecs[11] = mk(1'b0, 1'b1, 3'b001, 32'h00006001, 32'h0000FFFF, 5'd17, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 4'b0000, 32'h0,        32'h0,        1'b0, 1'b1, 32'h00006001);
        vecs[12] = mk(1'b0, 1'b1, 3'b100, 32'h00007000, 32'h11223344, 5'd18, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 4'b0000, 32'h0,        32'h0,        1'b0, 1'b1, 32'h00007000);
        vecs[13] = mk(1'b1, 1'b0, 3'b000, 32'h00008000, 32'h0,        5'd19, 1'b0, 32'hAAAAAA7F, 1'b1, 32'h00008000, 1'b0, 4'b0000, 32'h0,        32'h0000007F, 1'b1, 1'b0, 32'h0);
        vecs[14] = mk(1'b0, 1'b0, 3'b000, 32'hFFFFFFFF, 32'h0,        5'd31, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 4'b0000, 32'h0,        32'hFFFFFFFF, 1'b0, 1'b0, 32'h0);

        // Reset: everything zero, including in_ready while reset is held
        rst_n         = 1'b0;
        drive_idle_inputs();
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = '0;
        mem_rsp_err   = 1'b0;
        out_ready     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset", 1'b0);
        rst_n = 1'b1;
        #1;
        check("reset_release_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 15; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
        end

        // Request stall of 4 cycles, a stray response in REQ, then an error
        // response on an LW to 0x10, then writeback backpressure.
        mem_req_ready = 1'b0;
        in_valid   = 1'b1;
        in_is_load = 1'b1;
        in_funct3  = 3'b010;
        in_res     = 32'h00000010;
        in_rd      = 5'd3;
        @(posedge clk); #1;
        drive_idle_inputs();
        for (int c = 0; c < 4; c++) begin
            check($sformatf("stall%0d_req_valid", c), 32'(mem_req_valid), 32'd1);
            check($sformatf("stall%0d_req_addr", c),  mem_req_addr,        32'h00000010);
            check($sformatf("stall%0d_req_ctl", c),
                  {23'd0, mem_req_we, mem_req_wstrb, out_valid, in_ready, 2'b00}, 32'd0);
            mem_rsp_valid = (c == 2);
            mem_rsp_rdata = 32'h55555555;
            @(posedge clk); #1;
            mem_rsp_valid = 1'b0;
        end
        check("stall_still_req", 32'(mem_req_valid), 32'd1);
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        check("stall_wait_req_drop", 32'(mem_req_valid), 32'd0);
        check("stall_wait_no_out",   32'(out_valid),     32'd0);
        mem_rsp_valid = 1'b1;
        mem_rsp_err   = 1'b1;
        mem_rsp_rdata = 32'h12345678;
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
        mem_rsp_err   = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check($sformatf("bp%0d_out_valid", c), 32'(out_valid),   32'd1);
            check($sformatf("bp%0d_in_ready", c),  32'(in_ready),    32'd0);
            check($sformatf("bp%0d_err", c),       32'(out_err),     32'd1);
            check($sformatf("bp%0d_wen", c),       32'(out_wen),     32'd0);
            check($sformatf("bp%0d_bad", c),       out_badaddr,      32'h00000010);
            check($sformatf("bp%0d_res", c),       out_res,          32'd0);
            check($sformatf("bp%0d_rd", c),        32'(out_rd),      32'd3);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_release_idle", {30'd0, in_ready, out_valid}, 32'b10);

        // Reset while waiting for a response. The late response must be
        // ignored, and a new op must then complete normally.
        in_valid   = 1'b1;
        in_is_load = 1'b1;
        in_funct3  = 3'b010;
        in_res     = 32'h00000020;
        in_rd      = 5'd4;
        @(posedge clk); #1;
        drive_idle_inputs();
        @(posedge clk); #1;
        check("rstw_in_wait", {30'd0, mem_req_valid, out_valid}, 32'd0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_all_zero("rstw_held", 1'b0);
        rst_n = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'h87654321;
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = '0;
        check_all_zero("rstw_after", 1'b1);
        run_vec(vecs[1], "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit placed directly downstream of the execute stage. It consumes the execute result (effective address or ALU result) together with the decoded memory op, and drives a single-outstanding request/response memory port. For loads it aligns and sign/zero-extends the returned data; for stores it builds byte strobes and shifted write data. All results go to writeback over a valid/ready handshake; non-memory ops pass through with one cycle of latency.

## Interface

Parameters:
- `XLEN`, 32: datapath width; only 32 is supported.
- `ADDR_W`, 32: memory address width.

Ports:
- Clock and reset are fixed: one clock; reset is synchronous and active-low. Ports are `clk_i` and `rst_n_i`.
- `clk_i` in 1: clock.
- `rst_n_i` in 1: synchronous reset, active-low.
- `in_valid_i` in 1: execute result valid.
- `in_ready_o` out 1: LSU can accept.
- `in_is_load_i` in 1, `in_is_store_i` in 1: op class; both 0 means non-memory. Both 1 is illegal.
- `in_funct3_i` in 3: RV32 size/sign field.
- `in_res_i` in XLEN: execute result; used as the effective address for memory ops.
- `in_wdata_i` in XLEN: store data (rs2).
- `in_rd_i` in 5: destination register.
- `in_wen_i` in 1: register write enable for non-memory ops.
- `mem_req_valid_o` out 1; `mem_req_ready_i` in 1: request handshake.
- `mem_req_we_o` out 1: 1 means write.
- `mem_req_addr_o` out ADDR_W: word-aligned address, `{addr[ADDR_W-1:2],2'b00}`.
- `mem_req_wdata_o` out XLEN; `mem_req_wstrb_o` out 4.
- `mem_rsp_valid_i` in 1; `mem_rsp_rdata_i` in XLEN; `mem_rsp_err_i` in 1: response. It is always accepted and there is no ready.
- `out_valid_o` out 1; `out_ready_i` in 1: writeback handshake.
- `out_res_o` out XLEN; `out_rd_o` out 5; `out_wen_o` out 1.
- `out_err_o` out 1: access fault, misalignment or illegal funct3.
- `out_badaddr_o` out ADDR_W: faulting address. It is 0 when `out_err_o` is 0.

## Operation

States are IDLE, REQ, WAIT and DONE.

- **IDLE**
  - `in_ready_o` = 1.
  - On `in_valid_i`, latch all inputs.
  - Non-memory op → DONE, with `out_res_o`=`in_res_i` and `out_wen_o`=`in_wen_i`.
  - Memory op that fails the check → DONE with `out_err_o`=1, `out_wen_o`=0 and no memory request.
  - Otherwise → REQ.
- **Check**
  - funct3 must be one of:
    - loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU;
    - stores: 000 SB, 001 SH, 010 SW.
  - Any other value is illegal.
  - Halfword requires `addr[0]`=0. Word requires `addr[1:0]`=0.
- **REQ**
  - `mem_req_valid_o`=1. Address, we, wdata and wstrb stay stable until `mem_req_ready_i`, then → WAIT.
- **WAIT**
  - On `mem_rsp_valid_i` → DONE.
  - If `mem_rsp_err_i`=1: `out_err_o`=1, `out_wen_o`=0, `out_badaddr_o`=latched address.
  - Load without error: `out_wen_o`=1 and `out_res_o`=extracted data.
  - Store without error: `out_wen_o`=0 and `out_res_o`=0.
- **DONE**
  - `out_valid_o`=1 and all `out_*` held stable until `out_ready_i`, then → IDLE.
- **Store formatting**, with `o` = `addr[1:0]`:
  - SB: wstrb=`4'b0001<<o`, wdata=`{4{wdata[7:0]}}`.
  - SH: wstrb=`4'b0011<<o`, wdata=`{2{wdata[15:0]}}`.
  - SW: wstrb=`4'b1111`, wdata=wdata.
- **Load formatting**:
  - Byte is `rdata[8*o+7 : 8*o]`; halfword is `rdata[8*o+15 : 8*o]`.
  - LB and LH sign-extend; LBU and LHU zero-extend.
  - Loads drive `mem_req_wstrb_o`=0 and `mem_req_wdata_o`=0.
- `mem_rsp_valid_i` outside WAIT is ignored.
- One transaction is in flight at most.

## Timing

- Reset (`rst_n_i`=0 at a rising edge):
  - state → IDLE;
  - all outputs 0, including `in_ready_o`, `mem_req_valid_o` and `out_valid_o`;
  - latched fields are cleared.
- Reset mid-transaction abandons it immediately. `mem_req_valid_o` drops on the next cycle, and a later response is ignored because the state is not WAIT.
- `in_ready_o` depends only on state, so there is no combinational path from the `out_*` or `mem_*` inputs.
- Latency is counted from input accept at edge T:
  - Non-memory or faulting op: `out_valid_o` is high in cycle T+1.
  - Memory op: `mem_req_valid_o` is high from T+1. With the request accepted at edge R and the response at edge S>R, `out_valid_o` is high from S+1.
  - Minimum load/store latency is 3 cycles.
- Throughput: next accept no earlier than the cycle after the `out_valid_o`/`out_ready_i` handshake, so back-to-back non-memory ops take 2 cycles each.
- Backpressure:
  - `mem_req_ready_i`=0 or `out_ready_i`=0 stalls indefinitely with outputs stable.
  - `mem_req_valid_o` never deasserts before `mem_req_ready_i` except on reset.
- A response in the same cycle as request acceptance is a protocol violation and is ignored.

## Test plan

- Non-memory op: `in_res_i`=0x1234, rd=5, wen=1, `out_ready_i`=1 → `out_valid_o` one cycle later with res=0x1234, rd=5, wen=1, err=0; no `mem_req_valid_o`.
- LB at 0x80000003, rdata=0x80FF_FF7F → req addr 0x80000000, we=0, wstrb=0; `out_res_o`=0xFFFFFF80, wen=1. LBU with the same stimulus gives 0x00000080.
- SH at 0x80000002 with wdata=0xDEADBEEF → wstrb=4'b1100, wdata=0xBEEFBEEF, we=1; `out_wen_o`=0, err=0.
- LW at 0x80000006 → no memory request; next cycle err=1, badaddr=0x80000006, wen=0. Repeat with funct3=011 on a load → err=1.
- Stalls: `mem_req_ready_i` low for 4 cycles, then `mem_rsp_err_i`=1 on a load to 0x10 → request stable for all 4 cycles; then err=1, badaddr=0x10. `out_ready_i` low for 3 cycles → outputs stable, `in_ready_o`=0 throughout.
- Reset in WAIT: assert `rst_n_i`=0 for one cycle, then return a response → ignored; all outputs 0, `in_ready_o`=1 after reset, and a new op completes normally.
